// File: rtl/bc_msg_arbiter.sv
// bc_msg_arbiter: merges per-core broadcast messages into one registered
// broadcast stream. Each core owns a one-entry holding register; a
// round-robin grant moves at most one held message per cycle onto the bus.
module bc_msg_arbiter #(
  parameter int CORE_COUNT    = 16,
  parameter int CORE_ID_WIDTH = $clog2(CORE_COUNT),
  parameter int MSG_WIDTH     = 46
) (
  input  logic                            sys_clk,
  input  logic                            sys_rst,
  input  logic [CORE_COUNT-1:0]           core_rst_mask,
  input  logic [CORE_COUNT*MSG_WIDTH-1:0] core_msg_in,
  input  logic [CORE_COUNT-1:0]           core_msg_in_valid,
  output logic [CORE_COUNT-1:0]           core_msg_in_ready,
  input  logic                            bc_enable,
  output logic [MSG_WIDTH-1:0]            bc_msg_out,
  output logic                            bc_msg_out_valid,
  output logic [CORE_ID_WIDTH-1:0]        bc_msg_out_core,
  output logic [31:0]                     bc_msg_count
);

  logic [CORE_COUNT-1:0]    hold_valid;
  logic [MSG_WIDTH-1:0]     hold_data [CORE_COUNT];
  logic [CORE_COUNT-1:0]    req;
  logic [CORE_COUNT-1:0]    grant;
  logic                     grant_any;
  logic [CORE_ID_WIDTH-1:0] grant_idx;

  logic [CORE_ID_WIDTH-1:0] last_ptr_reg;
  logic [MSG_WIDTH-1:0]     out_data_reg;
  logic                     out_valid_reg;
  logic [CORE_ID_WIDTH-1:0] out_core_reg;
  logic [31:0]              count_reg;

  // Cores held in reset never request, even if their slot is still marked full.
  assign req = bc_enable ? (hold_valid & ~core_rst_mask) : '0;

  // Round-robin scan: first requester above last_ptr wins; if none, the
  // lowest requester overall wins, which covers the wrap and last_ptr itself.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    for (int i = 0; i < CORE_COUNT; i++) begin
      if (!grant_any && req[i] && (i > int'(last_ptr_reg))) begin
        grant_any = 1'b1;
        grant_idx = CORE_ID_WIDTH'(i);
      end
    end
    for (int i = 0; i < CORE_COUNT; i++) begin
      if (!grant_any && req[i]) begin
        grant_any = 1'b1;
        grant_idx = CORE_ID_WIDTH'(i);
      end
    end
  end

  // One-hot grant vector derived from the encoded winner.
  always_comb begin
    grant = '0;
    if (grant_any) begin
      grant[grant_idx] = 1'b1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < CORE_COUNT; gi++) begin : g_hold
      logic                 valid_reg;
      logic [MSG_WIDTH-1:0] data_reg;
      logic                 accept;

      // A granted slot may refill in the same cycle, so a lone core streams at full rate.
      assign core_msg_in_ready[gi] = !core_rst_mask[gi] && (!valid_reg || grant[gi]);
      assign accept                = core_msg_in_valid[gi] && core_msg_in_ready[gi];
      assign hold_valid[gi]        = valid_reg;
      assign hold_data[gi]         = data_reg;

      // Slot occupancy: flushed by block or core reset, set on accept, cleared on grant.
      always_ff @(posedge sys_clk) begin
        if (sys_rst || core_rst_mask[gi]) begin
          valid_reg <= 1'b0;
        end else if (accept) begin
          valid_reg <= 1'b1;
        end else if (grant[gi]) begin
          valid_reg <= 1'b0;
        end
      end

      // Slot payload: only meaningful while valid_reg is set, so no reset needed.
      always_ff @(posedge sys_clk) begin
        if (accept) begin
          data_reg <= core_msg_in[gi*MSG_WIDTH +: MSG_WIDTH];
        end
      end
    end
  endgenerate

  // Broadcast output register, round-robin pointer and message counter.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      last_ptr_reg  <= CORE_ID_WIDTH'(CORE_COUNT - 1);
      out_data_reg  <= '0;
      out_valid_reg <= 1'b0;
      out_core_reg  <= '0;
      count_reg     <= '0;
    end else begin
      out_valid_reg <= grant_any;
      if (grant_any) begin
        last_ptr_reg <= grant_idx;
        out_data_reg <= hold_data[grant_idx];
        out_core_reg <= grant_idx;
        count_reg    <= count_reg + 32'd1;
      end
    end
  end

  assign bc_msg_out       = out_data_reg;
  assign bc_msg_out_valid = out_valid_reg;
  assign bc_msg_out_core  = out_core_reg;
  assign bc_msg_count     = count_reg;

endmodule

// File: tb/tb_bc_msg_arbiter.sv
// Testbench for bc_msg_arbiter: directed scenarios with fixed expectations
// plus a randomized run checked against a cycle-level reference model.
module tb_bc_msg_arbiter;
  localparam int N  = 16;
  localparam int W  = 46;
  localparam int IW = 4;

  logic           clk;
  logic           rst;
  logic [N-1:0]   mask;
  logic [N*W-1:0] msg_in;
  logic [N-1:0]   valid;
  logic [N-1:0]   ready;
  logic           en;
  logic [W-1:0]   out;
  logic           out_valid;
  logic [IW-1:0]  out_core;
  logic [31:0]    count;

  int test_cnt = 0;
  int fail_cnt = 0;

  // Reference model state
  logic         m_hv [N];
  logic [W-1:0] m_hd [N];
  int           m_last;
  logic [W-1:0] m_out;
  int           m_core;
  logic         m_valid;
  logic [31:0]  m_count;

  bc_msg_arbiter #(.CORE_COUNT(N), .CORE_ID_WIDTH(IW), .MSG_WIDTH(W)) dut (
    .sys_clk(clk), .sys_rst(rst), .core_rst_mask(mask), .core_msg_in(msg_in),
    .core_msg_in_valid(valid), .core_msg_in_ready(ready), .bc_enable(en),
    .bc_msg_out(out), .bc_msg_out_valid(out_valid), .bc_msg_out_core(out_core),
    .bc_msg_count(count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Next core in round-robin order after the last winner, or -1.
  function automatic int m_pick();
    int idx;
    if (!en) return -1;
    for (int k = 1; k <= N; k++) begin
      idx = (m_last + k) % N;
      if (m_hv[idx] && !mask[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] m_ready();
    logic [N-1:0] r;
    int g;
    g = m_pick();
    for (int i = 0; i < N; i++) r[i] = !mask[i] && (!m_hv[i] || g == i);
    return r;
  endfunction

  task automatic model_step();
    int g;
    logic [N-1:0] r;
    if (rst) begin
      for (int i = 0; i < N; i++) m_hv[i] = 1'b0;
      m_last = N - 1; m_out = '0; m_core = 0; m_valid = 1'b0; m_count = '0;
    end else begin
      g = m_pick();
      r = m_ready();
      if (g >= 0) begin
        m_out = m_hd[g]; m_core = g; m_valid = 1'b1; m_count = m_count + 1; m_last = g;
      end else begin
        m_valid = 1'b0;
      end
      for (int i = 0; i < N; i++) begin
        if (mask[i]) m_hv[i] = 1'b0;
        else if (valid[i] && r[i]) begin m_hv[i] = 1'b1; m_hd[i] = msg_in[i*W +: W]; end
        else if (g == i) m_hv[i] = 1'b0;
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic set_msg(input int i, input logic [W-1:0] d);
    msg_in[i*W +: W] = d;
  endtask

  function automatic logic [W-1:0] rand_msg();
    return W'({$urandom(), $urandom()});
  endfunction

  task automatic apply_reset();
    rst = 1'b1; mask = '0; valid = '0; en = 1'b1;
    cycle(); cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; mask = 16'hA5C3; valid = 16'hFFFF; en = 1'b1;
    cycle(); cycle();
    test_cnt++; if (out_valid !== 1'b0) begin fail_cnt++; $display("FAIL reset_valid got %b want 0", out_valid); end
    test_cnt++; if (out !== '0) begin fail_cnt++; $display("FAIL reset_out got %h want 0", out); end
    test_cnt++; if (out_core !== '0) begin fail_cnt++; $display("FAIL reset_core got %0d want 0", out_core); end
    test_cnt++; if (count !== 32'd0) begin fail_cnt++; $display("FAIL reset_count got %0d want 0", count); end
    test_cnt++; if (ready !== 16'h5A3C) begin fail_cnt++; $display("FAIL reset_ready got %h want 5a3c", ready); end
    valid = '0; mask = 16'h0F00; rst = 1'b0;
    #1;
    test_cnt++; if (ready !== 16'hF0FF) begin fail_cnt++; $display("FAIL post_reset_ready got %h want f0ff", ready); end
    mask = '0;
    $display("[TB] test_reset done");
  endtask

  task automatic test_single();
    logic [W-1:0] d;
    d = 46'h1234_ABCD_EF01;
    apply_reset();
    set_msg(3, d); valid = 16'h0008;
    #1;
    test_cnt++; if (ready[3] !== 1'b1) begin fail_cnt++; $display("FAIL single_ready got %b want 1", ready[3]); end
    cycle(); valid = '0;
    test_cnt++; if (out_valid !== 1'b0) begin fail_cnt++; $display("FAIL single_early got %b want 0", out_valid); end
    cycle();
    test_cnt++; if (out_valid !== 1'b1) begin fail_cnt++; $display("FAIL single_valid got %b want 1", out_valid); end
    test_cnt++; if (out_core !== 4'd3) begin fail_cnt++; $display("FAIL single_core got %0d want 3", out_core); end
    test_cnt++; if (out !== d) begin fail_cnt++; $display("FAIL single_data got %h want %h", out, d); end
    test_cnt++; if (count !== 32'd1) begin fail_cnt++; $display("FAIL single_count got %0d want 1", count); end
    cycle();
    test_cnt++; if (out_valid !== 1'b0) begin fail_cnt++; $display("FAIL single_pulse got %b want 0", out_valid); end
    test_cnt++; if (out !== d) begin fail_cnt++; $display("FAIL single_hold got %h want %h", out, d); end
    $display("[TB] test_single done");
  endtask

  task automatic test_all_cores();
    logic [W-1:0] d [N];
    apply_reset();
    for (int i = 0; i < N; i++) begin d[i] = rand_msg(); set_msg(i, d[i]); end
    valid = '1;
    cycle(); valid = '0;
    cycle();
    for (int k = 0; k < N; k++) begin
      test_cnt++;
      if (out_valid !== 1'b1 || out_core !== IW'(k) || out !== d[k] || count !== 32'(k + 1)) begin
        fail_cnt++;
        $display("FAIL all_cores slot %0d got v=%b core=%0d data=%h cnt=%0d want v=1 core=%0d data=%h cnt=%0d",
                 k, out_valid, out_core, out, count, k, d[k], k + 1);
      end
      cycle();
    end
    test_cnt++; if (out_valid !== 1'b0 || count !== 32'd16) begin fail_cnt++; $display("FAIL all_cores_end got v=%b cnt=%0d want v=0 cnt=16", out_valid, count); end
    $display("[TB] test_all_cores done");
  endtask

  task automatic test_three_cores();
    int seq [3];
    int cnt [N];
    int n;
    seq[0] = 2; seq[1] = 5; seq[2] = 9; n = 0;
    for (int i = 0; i < N; i++) cnt[i] = 0;
    apply_reset();
    valid = 16'h0224;
    set_msg(2, rand_msg()); set_msg(5, rand_msg()); set_msg(9, rand_msg());
    cycle();
    for (int c = 0; c < 300; c++) begin
      set_msg(2, rand_msg()); set_msg(5, rand_msg()); set_msg(9, rand_msg());
      cycle();
      if (out_valid === 1'b1) begin
        test_cnt++;
        if (out_core !== IW'(seq[n % 3]) || out !== m_out) begin
          fail_cnt++;
          $display("FAIL rr_order #%0d got core=%0d data=%h want core=%0d data=%h", n, out_core, out, seq[n % 3], m_out);
        end
        cnt[out_core]++; n++;
      end
    end
    valid = '0;
    test_cnt++; if (n < 299 || n > 300) begin fail_cnt++; $display("FAIL rr_total got %0d want 300", n); end
    for (int j = 0; j < 3; j++) begin
      test_cnt++;
      if (cnt[seq[j]] < 99 || cnt[seq[j]] > 101) begin
        fail_cnt++; $display("FAIL rr_share core %0d got %0d want 100+-1", seq[j], cnt[seq[j]]);
      end
    end
    cycle(); cycle(); cycle();
    $display("[TB] test_three_cores done");
  endtask

  task automatic test_core_reset();
    apply_reset();
    en = 1'b0;
    set_msg(4, rand_msg()); valid = 16'h0010;
    cycle(); valid = '0;
    mask = 16'h0010;
    #1;
    test_cnt++; if (ready[4] !== 1'b0) begin fail_cnt++; $display("FAIL core_rst_ready_during got %b want 0", ready[4]); end
    cycle(); mask = '0;
    #1;
    test_cnt++; if (ready[4] !== 1'b1) begin fail_cnt++; $display("FAIL core_rst_ready_after got %b want 1", ready[4]); end
    en = 1'b1;
    for (int c = 0; c < 4; c++) begin
      cycle();
      test_cnt++; if (out_valid !== 1'b0) begin fail_cnt++; $display("FAIL core_rst_discard cycle %0d got valid %b want 0", c, out_valid); end
    end
    test_cnt++; if (count !== 32'd0) begin fail_cnt++; $display("FAIL core_rst_count got %0d want 0", count); end
    $display("[TB] test_core_reset done");
  endtask

  task automatic test_enable();
    logic [W-1:0] d0, d7;
    apply_reset();
    en = 1'b0;
    d0 = rand_msg(); d7 = rand_msg();
    set_msg(0, d0); set_msg(7, d7); valid = 16'h0081;
    cycle();
    for (int c = 0; c < 10; c++) begin
      set_msg(0, rand_msg()); set_msg(7, rand_msg());
      #1;
      test_cnt++; if (ready[0] !== 1'b0 || ready[7] !== 1'b0) begin fail_cnt++; $display("FAIL en_ready cycle %0d got %b%b want 00", c, ready[0], ready[7]); end
      cycle();
      test_cnt++; if (out_valid !== 1'b0) begin fail_cnt++; $display("FAIL en_frozen cycle %0d got valid %b want 0", c, out_valid); end
    end
    valid = '0; en = 1'b1;
    cycle();
    test_cnt++; if (out_valid !== 1'b1 || out_core !== 4'd0 || out !== d0) begin fail_cnt++; $display("FAIL en_first got v=%b core=%0d data=%h want v=1 core=0 data=%h", out_valid, out_core, out, d0); end
    cycle();
    test_cnt++; if (out_valid !== 1'b1 || out_core !== 4'd7 || out !== d7) begin fail_cnt++; $display("FAIL en_second got v=%b core=%0d data=%h want v=1 core=7 data=%h", out_valid, out_core, out, d7); end
    test_cnt++; if (count !== 32'd2) begin fail_cnt++; $display("FAIL en_count got %0d want 2", count); end
    cycle();
    $display("[TB] test_enable done");
  endtask

  task automatic test_sys_rst();
    logic [W-1:0] d;
    apply_reset();
    set_msg(9, rand_msg()); valid = 16'h0200;
    cycle(); valid = '0;
    cycle();
    test_cnt++; if (out_valid !== 1'b1 || out_core !== 4'd9) begin fail_cnt++; $display("FAIL sysrst_pre got v=%b core=%0d want v=1 core=9", out_valid, out_core); end
    en = 1'b0;
    for (int i = 0; i < N; i++) set_msg(i, rand_msg());
    valid = 16'h1446;
    cycle(); valid = '0;
    rst = 1'b1;
    cycle(); rst = 1'b0;
    test_cnt++; if (out_valid !== 1'b0 || out !== '0 || out_core !== '0 || count !== 32'd0) begin
      fail_cnt++; $display("FAIL sysrst_outputs got v=%b data=%h core=%0d cnt=%0d want all 0", out_valid, out, out_core, count);
    end
    en = 1'b1;
    for (int c = 0; c < 3; c++) begin
      cycle();
      test_cnt++; if (out_valid !== 1'b0) begin fail_cnt++; $display("FAIL sysrst_dropped cycle %0d got valid %b want 0", c, out_valid); end
    end
    d = rand_msg(); set_msg(15, d); valid = 16'h8000;
    cycle(); valid = '0;
    cycle();
    test_cnt++; if (out_valid !== 1'b1 || out_core !== 4'd15 || out !== d || count !== 32'd1) begin
      fail_cnt++; $display("FAIL sysrst_next got v=%b core=%0d data=%h cnt=%0d want v=1 core=15 data=%h cnt=1", out_valid, out_core, out, count, d);
    end
    $display("[TB] test_sys_rst done");
  endtask

  task automatic test_random();
    logic [N-1:0] er;
    apply_reset();
    for (int c = 0; c < 3000; c++) begin
      rst   = ($urandom_range(0, 299) == 0);
      mask  = ($urandom_range(0, 7) == 0) ? (N'($urandom()) & N'($urandom())) : '0;
      en    = ($urandom_range(0, 9) != 0);
      valid = N'($urandom());
      for (int i = 0; i < N; i++) set_msg(i, rand_msg());
      #1;
      er = m_ready();
      test_cnt++; if (ready !== er) begin fail_cnt++; $display("FAIL rand_ready cycle %0d got %h want %h", c, ready, er); end
      cycle();
      test_cnt++;
      if (out_valid !== m_valid || out_core !== IW'(m_core) || out !== m_out || count !== m_count) begin
        fail_cnt++;
        $display("FAIL rand_out cycle %0d got v=%b core=%0d data=%h cnt=%0d want v=%b core=%0d data=%h cnt=%0d",
                 c, out_valid, out_core, out, count, m_valid, m_core, m_out, m_count);
      end
    end
    rst = 1'b0; mask = '0; valid = '0;
    $display("[TB] test_random done, %0d broadcasts", m_count);
  endtask

  initial begin
    rst = 1'b1; mask = '0; msg_in = '0; valid = '0; en = 1'b1;
    @(negedge clk);
    test_reset();
    test_single();
    test_all_cores();
    test_three_cores();
    test_core_reset();
    test_enable();
    test_sys_rst();
    test_random();
    $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
    $finish;
  end

endmodule
